// File: rtl/fe_pkg.sv
// -----------------------------------------------------------------------------
// fe_pkg
// Shared definitions for the fetch front-end and its consumers.
//   - Default widths used by the decode-side view of a fetch-queue entry.
//   - INSTSIZE : PC increment per instruction.
//   - STARTPC  : PC after reset.
//   - fe_entry_t / FE_ENTRY_BITS : one fetch-queue entry, so DE can unpack a
//     flat bus without re-deriving the field layout.
// -----------------------------------------------------------------------------
package fe_pkg;

  localparam int unsigned FE_DBITS    = 32;
  localparam int unsigned FE_INSTBITS = 32;
  localparam int unsigned FE_CNTBITS  = 32;

  localparam int unsigned INSTSIZE = 4;
  localparam logic [FE_DBITS-1:0] STARTPC = 32'h0000_0100;

  // Field order is the packing order: inst occupies the MSBs.
  typedef struct packed {
    logic [FE_INSTBITS-1:0] inst;
    logic [FE_DBITS-1:0]    pc;
    logic [FE_DBITS-1:0]    pcplus;
    logic [FE_CNTBITS-1:0]  count;
  } fe_entry_t;

  localparam int unsigned FE_ENTRY_BITS = $bits(fe_entry_t);

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO of fetch entries with a flush that overrides push and pop.
// Pointers carry one extra MSB so full (MSBs differ, low bits equal) and
// empty (pointers equal) are distinguishable without a separate counter.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (pointers only)
//   push       in   write push_data at the tail
//   push_data  in   entry to write
//   pop        in   advance the head (ignored when empty)
//   flush      in   empty the queue; wins over push and pop
//   head       out  entry at the head (unregistered read of storage)
//   occupancy  out  number of entries held, 0..DEPTH
//   full       out  occupancy == DEPTH
//   empty      out  occupancy == 0
// -----------------------------------------------------------------------------
module fetch_queue
  import fe_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fe_entry_t,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  entry_t  push_data,
  input  logic    pop,
  input  logic    flush,
  output entry_t  head,
  output logic [AW:0] occupancy,
  output logic    full,
  output logic    empty
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and >= 2");
  end

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  entry_t      mem [DEPTH];

  logic do_push;
  logic do_pop;

  // A push into a full queue is only legal when the head leaves the same
  // cycle; the write then lands in the slot being vacated.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone
  // define which slots hold live data, so resetting the array buys nothing.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  assign head      = mem[rd_ptr_q[AW-1:0]];
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/fe_fetch_queue_stage.sv
// -----------------------------------------------------------------------------
// fe_fetch_queue_stage
// Fetch front-end: drives a 1-cycle-latency instruction memory and buffers
// returned instructions in a FETCH_DEPTH-entry queue that DE drains through a
// valid/ready handshake. An AGEX redirect flushes the queue, squashes the
// in-flight fetch and restarts at the target PC.
//
// Ports:
//   clk             in   clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   imem_req_valid  out  fetch request this cycle
//   imem_req_addr   out  byte address of the request (current fetch PC)
//   imem_rsp_valid  in   response, exactly one cycle after a request
//   imem_rsp_data   in   fetched instruction
//   redirect_valid  in   AGEX branch/jump taken
//   redirect_pc     in   redirect target
//   out_valid       out  queue head valid to DE
//   out_ready       in   DE accepts the head
//   out_inst        out  head instruction
//   out_pc          out  head PC
//   out_pcplus      out  head PC + INSTSIZE
//   out_count       out  debug sequence number of the head
//   fq_occupancy    out  entries held in the queue
// -----------------------------------------------------------------------------
module fe_fetch_queue_stage #(
  parameter int unsigned       DBITS       = fe_pkg::FE_DBITS,
  parameter int unsigned       INSTBITS    = fe_pkg::FE_INSTBITS,
  parameter int unsigned       INSTSIZE    = fe_pkg::INSTSIZE,
  parameter logic [DBITS-1:0]  STARTPC     = DBITS'(fe_pkg::STARTPC),
  parameter int unsigned       FETCH_DEPTH = 4,
  parameter int unsigned       CNTBITS     = fe_pkg::FE_CNTBITS,
  localparam int unsigned      OCCW        = $clog2(FETCH_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                imem_req_valid,
  output logic [DBITS-1:0]    imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [INSTBITS-1:0] imem_rsp_data,
  input  logic                redirect_valid,
  input  logic [DBITS-1:0]    redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTBITS-1:0] out_inst,
  output logic [DBITS-1:0]    out_pc,
  output logic [DBITS-1:0]    out_pcplus,
  output logic [CNTBITS-1:0]  out_count,
  output logic [OCCW-1:0]     fq_occupancy
);

  // Same layout as fe_pkg::fe_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [INSTBITS-1:0] inst;
    logic [DBITS-1:0]    pc;
    logic [DBITS-1:0]    pcplus;
    logic [CNTBITS-1:0]  count;
  } entry_t;

  localparam logic [DBITS-1:0]   PC_STEP   = DBITS'(INSTSIZE);
  localparam logic [CNTBITS-1:0] COUNT_ONE = CNTBITS'(1);

  // Fetch state
  logic [DBITS-1:0]   pc_q;        // next address to request
  logic [DBITS-1:0]   req_pc_q;    // address of the request now in flight
  logic               inflight_q;  // a request was issued last cycle
  logic               drop_q;      // discard the response arriving this cycle
  logic               live_q;      // low only in the first cycle after reset
  logic [CNTBITS-1:0] count_q;     // sequence number for the next enqueue

  logic   issue;
  logic   enq;
  logic   deq;
  logic   fq_full;
  logic   fq_empty;
  entry_t enq_entry;
  entry_t head;

  // Credit check: an issued request always has a free slot when its response
  // returns, counting the one already in flight. Gating with reset_n keeps
  // the request port quiet while reset is held.
  // NOTE: combinational blocks assign every output a default first, so no
  // path through the block leaves a signal holding state (no latches).
  always_comb begin
    issue     = 1'b0;
    enq       = 1'b0;
    deq       = 1'b0;
    enq_entry = '0;
    if (reset_n && !redirect_valid &&
        ((32'(fq_occupancy) + 32'(inflight_q)) < FETCH_DEPTH)) begin
      issue = 1'b1;
    end
    // A response is kept only if nothing told us it is stale: a redirect
    // this cycle, a redirect last cycle (drop_q), or reset just released.
    if (imem_rsp_valid && !drop_q && live_q && !redirect_valid) begin
      enq = 1'b1;
    end
    deq              = out_valid && out_ready;
    enq_entry.inst   = imem_rsp_data;
    enq_entry.pc     = req_pc_q;
    enq_entry.pcplus = req_pc_q + PC_STEP;
    enq_entry.count  = count_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= STARTPC;
      req_pc_q   <= STARTPC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      live_q     <= 1'b0;
      count_q    <= COUNT_ONE;
    end else begin
      live_q     <= 1'b1;
      inflight_q <= issue;
      drop_q     <= redirect_valid && inflight_q;
      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end else if (issue) begin
        pc_q     <= pc_q + PC_STEP;
        req_pc_q <= pc_q;
      end
      // Only instructions that actually enter the queue consume a number.
      if (enq) begin
        count_q <= count_q + COUNT_ONE;
      end
    end
  end

  fetch_queue #(
    .DEPTH   (FETCH_DEPTH),
    .entry_t (entry_t)
  ) u_fetch_queue (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (enq),
    .push_data (enq_entry),
    .pop       (deq),
    .flush     (redirect_valid),
    .head      (head),
    .occupancy (fq_occupancy),
    .full      (fq_full),
    .empty     (fq_empty)
  );

  assign imem_req_valid = issue;
  assign imem_req_addr  = pc_q;

  // Head fields are forced to zero while the queue is empty so that DE
  // never sees uninitialised storage contents.
  assign out_valid  = !fq_empty;
  assign out_inst   = out_valid ? head.inst   : '0;
  assign out_pc     = out_valid ? head.pc     : '0;
  assign out_pcplus = out_valid ? head.pcplus : '0;
  assign out_count  = out_valid ? head.count  : '0;

  // The credit rule must make an enqueue into a full queue impossible.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (!reset_n) !(enq && fq_full && !deq)
  );

endmodule
